// File: rtl/sdram_pattern_tester.sv
// Self-test engine for sdram_controller: writes an address-derived pattern over [START_ADDR..END_ADDR], then reads back and compares.
// Latency: one request per word per pass; a request issues two cycles after the previous ack, or on the cycle after istart.
// Backpressure: holds each req with stable address/data until the one-cycle ack, bounded by a per-request watchdog.
module sdram_pattern_tester #(
  parameter int                ADDR_W      = 22,
  parameter int                DATA_W      = 128,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [ADDR_W-1:0] END_ADDR    = ADDR_W'(255),
  parameter logic [31:0]       SEED        = 32'hA5C3_0F1E,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              istart,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  output logic              obusy,
  output logic              odone,
  output logic              opass,
  output logic              otimeout,
  output logic [15:0]       oerr_count,
  output logic [ADDR_W-1:0] ofirst_err_addr
);

  // The pattern is four 32-bit lanes, so the data path is fixed at 128 bits.
  if (DATA_W != 128) begin : g_bad_data_w
    $error("sdram_pattern_tester: DATA_W must be 128");
  end
  if (START_ADDR > END_ADDR) begin : g_bad_range
    $error("sdram_pattern_tester: START_ADDR must not exceed END_ADDR");
  end

  localparam int               WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_NEXT, S_RD_REQ, S_RD_CHECK, S_DONE
  } state_t;

  // Lanes alternate inverted/true pattern so adjacent data bits toggle.
  function automatic logic [127:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] p;
    p = 32'(a) ^ SEED;
    return {~p, p, ~p, p};
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] capture_q, capture_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              wreq_q, wreq_d;
  logic              rreq_q, rreq_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] addr_inc;
  logic [15:0]       err_next;

  assign addr_inc = addr_q + ADDR_W'(1);

  // Next-state and next-output logic; wdata_q always tracks pattern(addr_q) once a run starts.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    capture_d = capture_q;
    wdog_d    = wdog_q;
    wreq_d    = wreq_q;
    rreq_d    = rreq_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    first_d   = first_q;
    err_next  = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (istart) begin
          addr_d    = START_ADDR;
          wdata_d   = pattern(START_ADDR);
          err_d     = '0;
          first_d   = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          wdog_d    = '0;
          wreq_d    = 1'b1;
          state_d   = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        // An ack arriving on the last watchdog cycle still completes normally.
        if (iwrite_ack) begin
          wreq_d  = 1'b0;
          state_d = S_WR_NEXT;
        end else if (wdog_q == WD_LAST) begin
          wreq_d    = 1'b0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_WR_NEXT: begin
        wdog_d = '0;
        if (addr_q == END_ADDR) begin
          addr_d  = START_ADDR;
          wdata_d = pattern(START_ADDR);
          rreq_d  = 1'b1;
          state_d = S_RD_REQ;
        end else begin
          addr_d  = addr_inc;
          wdata_d = pattern(addr_inc);
          wreq_d  = 1'b1;
          state_d = S_WR_REQ;
        end
      end
      S_RD_REQ: begin
        if (iread_ack) begin
          capture_d = iread_data;
          rreq_d    = 1'b0;
          state_d   = S_RD_CHECK;
        end else if (wdog_q == WD_LAST) begin
          rreq_d    = 1'b0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_RD_CHECK: begin
        if (capture_q != wdata_q) begin
          if (err_q != 16'hFFFF) begin
            err_next = err_q + 16'd1;
          end
          if (err_q == 16'd0) begin
            first_d = addr_q;
          end
        end
        err_d  = err_next;
        wdog_d = '0;
        if (addr_q == END_ADDR) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == 16'd0) && !timeout_q;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_inc;
          wdata_d = pattern(addr_inc);
          rreq_d  = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      default: begin
        wreq_d  = 1'b0;
        rreq_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and all registered outputs, cleared by synchronous reset.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      capture_q <= '0;
      wdog_q    <= '0;
      wreq_q    <= 1'b0;
      rreq_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      capture_q <= capture_d;
      wdog_q    <= wdog_d;
      wreq_q    <= wreq_d;
      rreq_q    <= rreq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign owrite_req      = wreq_q;
  assign owrite_address  = addr_q;
  assign owrite_data     = wdata_q;
  assign oread_req       = rreq_q;
  assign oread_address   = addr_q;
  assign obusy           = busy_q;
  assign odone           = done_q;
  assign opass           = pass_q;
  assign otimeout        = timeout_q;
  assign oerr_count      = err_q;
  assign ofirst_err_addr = first_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench: DUT A covers 0..15 with a 64-cycle watchdog, DUT B covers the single word 5.
// Latency: each model acks a fixed number of cycles after seeing a req.
// Backpressure: models can withhold write acks, corrupt reads, or inject spurious acks.
module tb_sdram_pattern_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: START=0, END=15, TIMEOUT=64 ----------------
  logic         a_start = 1'b0;
  logic         a_wreq, a_rreq, a_busy, a_done, a_pass, a_tmo;
  logic [21:0]  a_waddr, a_raddr, a_first;
  logic [127:0] a_wdata;
  logic [127:0] a_rdata = '0;
  logic         a_wack = 1'b0;
  logic         a_rack_m = 1'b0;
  logic         a_rack_spur = 1'b0;
  logic         a_rack;
  logic [15:0]  a_err;
  assign a_rack = a_rack_m | a_rack_spur;

  sdram_pattern_tester #(
    .START_ADDR(22'h0), .END_ADDR(22'hF), .TIMEOUT_CYC(64)
  ) u_dut_a (
    .iclk(clk), .ireset(rst), .istart(a_start),
    .owrite_req(a_wreq), .owrite_address(a_waddr), .owrite_data(a_wdata), .iwrite_ack(a_wack),
    .oread_req(a_rreq), .oread_address(a_raddr), .iread_data(a_rdata), .iread_ack(a_rack),
    .obusy(a_busy), .odone(a_done), .opass(a_pass), .otimeout(a_tmo),
    .oerr_count(a_err), .ofirst_err_addr(a_first)
  );

  // ---------------- DUT B: START=END=5 ----------------
  logic         b_start = 1'b0;
  logic         b_wreq, b_rreq, b_busy, b_done, b_pass, b_tmo;
  logic [21:0]  b_waddr, b_raddr, b_first;
  logic [127:0] b_wdata;
  logic [127:0] b_rdata = '0;
  logic         b_wack = 1'b0;
  logic         b_rack = 1'b0;
  logic [15:0]  b_err;

  sdram_pattern_tester #(
    .START_ADDR(22'h5), .END_ADDR(22'h5)
  ) u_dut_b (
    .iclk(clk), .ireset(rst), .istart(b_start),
    .owrite_req(b_wreq), .owrite_address(b_waddr), .owrite_data(b_wdata), .iwrite_ack(b_wack),
    .oread_req(b_rreq), .oread_address(b_raddr), .iread_data(b_rdata), .iread_ack(b_rack),
    .obusy(b_busy), .odone(b_done), .opass(b_pass), .otimeout(b_tmo),
    .oerr_count(b_err), .ofirst_err_addr(b_first)
  );

  // ---------------- memory models ----------------
  logic [127:0] mem_a [0:255];
  logic [127:0] mem_b;
  int  a_wlog[$];
  int  a_rlog[$];
  int  a_overlap = 0;
  bit  no_wack = 1'b0;
  bit  flip = 1'b0;
  int  b_wcount = 0;
  int  b_rcount = 0;
  logic [21:0]  b_last_waddr = '0;
  logic [127:0] b_last_wdata = '0;

  // DUT A model: ack on the 2nd cycle a req is seen high
  initial begin
    int wcnt, rcnt;
    wcnt = 0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      a_wack = 1'b0;
      a_rack_m = 1'b0;
      if (a_wreq && a_rreq) a_overlap++;
      if (a_wreq) begin
        wcnt++;
        if (wcnt == 2 && !no_wack) begin
          a_wack = 1'b1;
          mem_a[a_waddr[7:0]] = a_wdata;
          a_wlog.push_back(int'(a_waddr));
        end
      end else wcnt = 0;
      if (a_rreq) begin
        rcnt++;
        if (rcnt == 2) begin
          a_rack_m = 1'b1;
          a_rdata = mem_a[a_raddr[7:0]];
          if (flip && (a_raddr == 22'd7 || a_raddr == 22'd9)) a_rdata[0] = ~a_rdata[0];
          a_rlog.push_back(int'(a_raddr));
        end
      end else rcnt = 0;
    end
  end

  // DUT B model: ack on the 3rd cycle a req is seen high
  initial begin
    int wcnt, rcnt;
    wcnt = 0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      b_wack = 1'b0;
      b_rack = 1'b0;
      if (b_wreq) begin
        wcnt++;
        if (wcnt == 3) begin
          b_wack = 1'b1;
          mem_b = b_wdata;
          b_last_waddr = b_waddr;
          b_last_wdata = b_wdata;
          b_wcount++;
        end
      end else wcnt = 0;
      if (b_rreq) begin
        rcnt++;
        if (rcnt == 3) begin
          b_rack = 1'b1;
          b_rdata = mem_b;
          b_rcount++;
        end
      end else rcnt = 0;
    end
  end

  task automatic pulse_a();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input string tag);
    int n;
    n = 0;
    while (!a_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, a_done, 1'b1);
  endtask

  task automatic chk_a_order(input string tag);
    bit ok;
    ok = (a_wlog.size() == 16) && (a_rlog.size() == 16);
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        if (a_wlog[i] != i || a_rlog[i] != i) ok = 1'b0;
      end
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    int n;
    // ---- reset ----
    repeat (3) @(negedge clk);
    chk("rst_a_ctrl", {a_wreq, a_rreq, a_busy, a_done, a_pass, a_tmo}, 6'b0);
    chk("rst_a_vals", {a_err, a_first, a_waddr, a_raddr}, '0);
    chk("rst_a_wdata", a_wdata, '0);
    chk("rst_b_ctrl", {b_wreq, b_rreq, b_busy, b_done, b_pass}, 5'b0);
    rst = 1'b0;
    @(negedge clk);

    // ---- test 1: single word at address 5 ----
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("t1_busy", b_busy, 1'b1);
    n = 0;
    while (!b_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t1_done", b_done, 1'b1);
    chk("t1_wcount", b_wcount, 1);
    chk("t1_rcount", b_rcount, 1);
    chk("t1_waddr", b_last_waddr, 22'h5);
    chk("t1_wdata", b_last_wdata, 128'h5A3CF0E4_A5C30F1B_5A3CF0E4_A5C30F1B);
    chk("t1_pass", {b_pass, b_tmo, b_busy}, 3'b100);
    chk("t1_err", b_err, 16'd0);

    // ---- test 2: clean run over 0..15 ----
    pulse_a();
    wait_a_done("t2");
    chk_a_order("t2_order");
    chk("t2_overlap", a_overlap, 0);
    chk("t2_pass", {a_pass, a_tmo, a_busy}, 3'b100);
    chk("t2_err", a_err, 16'd0);
    chk("t2_mem7", mem_a[7], 128'h5A3CF0E6_A5C30F19_5A3CF0E6_A5C30F19);

    // ---- test 3 + 6a: corrupt reads of 7 and 9, istart toggling while busy ----
    a_wlog.delete();
    a_rlog.delete();
    flip = 1'b1;
    pulse_a();
    chk("t3_busy", a_busy, 1'b1);
    repeat (20) begin
      @(negedge clk);
      a_start = ~a_start;
    end
    a_start = 1'b0;
    wait_a_done("t3");
    chk_a_order("t3_order");
    chk("t3_err", a_err, 16'd2);
    chk("t3_first", a_first, 22'd7);
    chk("t3_pass", a_pass, 1'b0);
    flip = 1'b0;

    // ---- test 6b: restart from DONE clears counters ----
    pulse_a();
    chk("t6_cleared", {a_err, a_first, a_done}, '0);
    wait_a_done("t6");
    chk("t6_pass", a_pass, 1'b1);
    chk("t6_err", {a_err, a_first}, '0);

    // ---- test 5: reset during read of address 3 ----
    pulse_a();
    n = 0;
    while (!(a_rreq && a_raddr == 22'd3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_rd3", a_rreq, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_ctrl", {a_wreq, a_rreq, a_busy, a_done, a_pass, a_tmo}, 6'b0);
    chk("t5_rst_vals", {a_err, a_first, a_waddr, a_wdata}, '0);
    a_rack_spur = 1'b1;
    @(negedge clk);
    a_rack_spur = 1'b0;
    @(negedge clk);
    chk("t5_spur_ignored", {a_wreq, a_rreq, a_busy, a_done, a_err}, '0);
    pulse_a();
    wait_a_done("t5");
    chk("t5_pass", a_pass, 1'b1);

    // ---- test 4: write never acked -> watchdog ----
    no_wack = 1'b1;
    pulse_a();
    n = 0;
    while (a_wreq && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t4_req_cycles", n, 64);
    chk("t4_flags", {a_tmo, a_done, a_pass, a_busy, a_wreq}, 5'b11000);
    no_wack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
